// File: rtl/vedic_mac_acc_if.sv
// Operand/result handshake bundle for the vedic dot-product stage.
// master drives operands and consumes results; slave is the MAC.
interface vedic_mac_acc_if #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] LEN;
   logic             IN_VALID;
   logic             IN_READY;
   logic [7:0]       A;
   logic [7:0]       B;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [ACC_W-1:0] ACC;
   logic             OVF;

   modport master (
      output LEN, IN_VALID, A, B, OUT_READY,
      input  IN_READY, OUT_VALID, ACC, OVF
   );

   modport slave (
      input  LEN, IN_VALID, A, B, OUT_READY,
      output IN_READY, OUT_VALID, ACC, OVF
   );
endinterface

// File: rtl/vedic_mac_acc.sv
// Streaming dot-product MAC: 3-stage pipe around an 8x8 vedic multiplier.
// One vector in flight at a time; result held until the consumer takes it.
module vedic_8bits (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   function automatic logic [3:0] v2(
      input logic [1:0] x,
      input logic [1:0] y
   );
      logic [1:0] s;
      logic [1:0] t;
      s = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
      t = {1'b0, x[1] & y[1]} + {1'b0, s[1]};
      return {t, s[0], x[0] & y[0]};
   endfunction

   function automatic logic [7:0] v4(
      input logic [3:0] x,
      input logic [3:0] y
   );
      logic [3:0] q0, q1, q2, q3;
      q0 = v2(x[1:0], y[1:0]);
      q1 = v2(x[3:2], y[1:0]);
      q2 = v2(x[1:0], y[3:2]);
      q3 = v2(x[3:2], y[3:2]);
      return {4'b0, q0} + {2'b0, q1, 2'b0}
           + {2'b0, q2, 2'b0} + {q3, 4'b0};
   endfunction

   logic [7:0] m0, m1, m2, m3;

   always_comb begin
      m0 = v4(a[3:0], b[3:0]);
      m1 = v4(a[7:4], b[3:0]);
      m2 = v4(a[3:0], b[7:4]);
      m3 = v4(a[7:4], b[7:4]);
      p  = {8'b0, m0} + {4'b0, m1, 4'b0}
         + {4'b0, m2, 4'b0} + {m3, 8'b0};
   end
endmodule

module vedic_mac_acc #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input logic             CLK,
   input logic             RST_n,
   input logic             CLR,
   vedic_mac_acc_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE, RUN, DRAIN, DONE
   } state_e;

   state_e           state_q, state_d;
   logic             rdy_en_q;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s1_v_q, s1_v_d;
   logic [7:0]       a_q, a_d;
   logic [7:0]       b_q, b_d;
   logic             s2_v_q, s2_v_d;
   logic [15:0]      p_q, p_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic [15:0]      prod;
   logic [ACC_W:0]   sum;
   logic [CNT_W-1:0] len_eff;
   logic [CNT_W-1:0] cnt_inc;
   logic             in_ready;
   logic             accept;

   vedic_8bits u_mul (
      .a (a_q),
      .b (b_q),
      .p (prod)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;

      in_ready = rdy_en_q & ~CLR
               & ((state_q == IDLE) | (state_q == RUN));
      accept   = in_ready & bus.IN_VALID;
      len_eff  = (bus.LEN == '0) ? CNT_W'(1) : bus.LEN;
      cnt_inc  = cnt_q + CNT_W'(1);

      s1_v_d = accept;
      if (accept) begin
         a_d = bus.A;
         b_d = bus.B;
      end

      s2_v_d = s1_v_q;
      if (s1_v_q) p_d = prod;

      // Carry out of the top bit is sticky for the whole vector.
      sum = {1'b0, acc_q} + (ACC_W+1)'(p_q);
      if (s2_v_q) begin
         acc_d = sum[ACC_W-1:0];
         ovf_d = ovf_q | sum[ACC_W];
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               len_d   = len_eff;
               cnt_d   = CNT_W'(1);
               state_d = (len_eff == CNT_W'(1)) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!s1_v_q && !s2_v_q) state_d = DONE;
         end
         DONE: begin
            if (bus.OUT_READY) begin
               state_d = IDLE;
               cnt_d   = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
            end
         end
      endcase

      if (CLR) begin
         state_d = IDLE;
         cnt_d   = '0;
         s1_v_d  = 1'b0;
         s2_v_d  = 1'b0;
         acc_d   = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q  <= IDLE;
         rdy_en_q <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         s1_v_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         s2_v_q   <= 1'b0;
         p_q      <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rdy_en_q <= 1'b1;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         s1_v_q   <= s1_v_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s2_v_q   <= s2_v_d;
         p_q      <= p_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.OUT_VALID = (state_q == DONE);
   assign bus.ACC       = acc_q;
   assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_vedic_mac_acc.sv
// Bench for vedic_mac_acc: 24-bit and 16-bit accumulators run in lockstep
// on the same stimulus, each checked against its own expected-result queue.
module tb_vedic_mac_acc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;

   always #5 clk = ~clk;

   vedic_mac_acc_if #(.ACC_W(24), .CNT_W(8)) i0 ();
   vedic_mac_acc_if #(.ACC_W(16), .CNT_W(8)) i1 ();

   assign i1.LEN       = i0.LEN;
   assign i1.IN_VALID  = i0.IN_VALID;
   assign i1.A         = i0.A;
   assign i1.B         = i0.B;
   assign i1.OUT_READY = i0.OUT_READY;

   vedic_mac_acc #(.ACC_W(24), .CNT_W(8)) d0 (
      .CLK   (clk),
      .RST_n (rst_n),
      .CLR   (clr),
      .bus   (i0)
   );

   vedic_mac_acc #(.ACC_W(16), .CNT_W(8)) d1 (
      .CLK   (clk),
      .RST_n (rst_n),
      .CLR   (clr),
      .bus   (i1)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [24:0] q0[$];
   logic [16:0] q1[$];
   logic [24:0] e0;
   logic [16:0] e1;
   logic [24:0] hold_e;

   int va[4];
   int vb[4];

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && i0.OUT_VALID && i0.OUT_READY) begin
         if (q0.size() == 0) chk("sb24_depth", 32'(q0.size()), 1);
         else begin
            e0 = q0.pop_front();
            chk("acc24", 32'(i0.ACC), 32'(e0[23:0]));
            chk("ovf24", 32'(i0.OVF), 32'(e0[24]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && i1.OUT_VALID && i1.OUT_READY) begin
         if (q1.size() == 0) chk("sb16_depth", 32'(q1.size()), 1);
         else begin
            e1 = q1.pop_front();
            chk("acc16", 32'(i1.ACC), 32'(e1[15:0]));
            chk("ovf16", 32'(i1.OVF), 32'(e1[16]));
         end
      end
   end

   task automatic run_vec(
      input int len,
      input int n,
      input int gap,
      input bit push
   );
      longint sum;
      bit     ok;
      sum = 0;
      i0.LEN = 8'(len);
      for (int i = 0; i < n; i++) begin
         i0.A = 8'(va[i]);
         i0.B = 8'(vb[i]);
         i0.IN_VALID = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = i0.IN_READY;
            @(posedge clk);
            #1;
         end
         if (!ok) chk("accept_timeout", 32'(ok), 1);
         sum += longint'(va[i] * vb[i]);
         if (i == 0) i0.LEN = 8'(len + 7);
         if (gap > 0 && i < n - 1) begin
            i0.IN_VALID = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      i0.IN_VALID = 1'b0;
      if (push) begin
         q0.push_back({sum >= 64'd16777216, 24'(sum)});
         q1.push_back({sum >= 64'd65536, 16'(sum)});
      end
   endtask

   task automatic wait_done();
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0) break;
      end
      chk("drain_timeout", 32'(q0.size() + q1.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_acc"}, 32'(i0.ACC), 0);
      chk({tag, "_ovf"}, 32'(i0.OVF), 0);
      chk({tag, "_ov"}, 32'(i0.OUT_VALID), 0);
      chk({tag, "_acc16"}, 32'(i1.ACC), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit got_ov;
      i0.LEN = 8'd0;
      i0.IN_VALID = 1'b0;
      i0.A = 8'd0;
      i0.B = 8'd0;
      i0.OUT_READY = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_ir", 32'(i0.IN_READY), 0);
      chk_idle("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ir", 32'(i0.IN_READY), 0);
      @(posedge clk);
      #1;

      // back-to-back LEN=4 with exact output latency
      va = '{3, 255, 16, 0};
      vb = '{5, 255, 16, 200};
      run_vec(4, 4, 0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("lat_ov", 32'(i0.OUT_VALID), (c == 3) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      wait_done();

      va = '{200, 0, 0, 0};
      vb = '{100, 0, 0, 0};
      run_vec(1, 1, 0, 1'b1);
      wait_done();
      va = '{7, 0, 0, 0};
      vb = '{9, 0, 0, 0};
      run_vec(0, 1, 0, 1'b1);
      wait_done();

      // consumer stall with IN_VALID held high
      i0.OUT_READY = 1'b0;
      va = '{10, 20, 0, 0};
      vb = '{10, 20, 0, 0};
      run_vec(2, 2, 0, 1'b1);
      hold_e = q0[0];
      got_ov = 1'b0;
      for (int k = 0; k < 20 && !got_ov; k++) begin
         @(negedge clk);
         got_ov = i0.OUT_VALID;
      end
      chk("hold_ov_timeout", 32'(got_ov), 1);
      i0.A = 8'd9;
      i0.B = 8'd9;
      i0.IN_VALID = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_acc", 32'(i0.ACC), 32'(hold_e[23:0]));
         chk("hold_ov", 32'(i0.OUT_VALID), 1);
         chk("hold_ir", 32'(i0.IN_READY), 0);
      end
      @(posedge clk);
      #1;
      i0.OUT_READY = 1'b1;
      @(posedge clk);
      #1;
      i0.IN_VALID = 1'b0;
      @(negedge clk);
      chk("ret_ir", 32'(i0.IN_READY), 1);
      chk("ret_acc", 32'(i0.ACC), 0);
      @(posedge clk);
      #1;
      va = '{1, 0, 0, 0};
      vb = '{1, 0, 0, 0};
      run_vec(1, 1, 0, 1'b1);
      wait_done();

      // bubbles between pairs
      va = '{12, 1, 128, 0};
      vb = '{12, 255, 2, 0};
      run_vec(3, 3, 2, 1'b1);
      wait_done();

      // 16-bit wrap sets OVF; next vector starts clean
      va = '{255, 255, 0, 0};
      vb = '{255, 255, 0, 0};
      run_vec(2, 2, 0, 1'b1);
      wait_done();
      va = '{1, 0, 0, 0};
      vb = '{1, 0, 0, 0};
      run_vec(1, 1, 0, 1'b1);
      wait_done();

      // abort with CLR mid-vector
      va = '{50, 70, 0, 0};
      vb = '{60, 80, 0, 0};
      run_vec(4, 2, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b1;
      @(negedge clk);
      chk("clr_ir", 32'(i0.IN_READY), 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      @(negedge clk);
      chk_idle("clr");
      @(posedge clk);
      #1;
      va = '{2, 4, 0, 0};
      vb = '{3, 5, 0, 0};
      run_vec(2, 2, 0, 1'b1);
      wait_done();

      // abort with async reset mid-vector
      va = '{50, 70, 0, 0};
      vb = '{60, 80, 0, 0};
      run_vec(4, 2, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_ir", 32'(i0.IN_READY), 0);
      chk_idle("rst2");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      va = '{2, 4, 0, 0};
      vb = '{3, 5, 0, 0};
      run_vec(2, 2, 0, 1'b1);
      wait_done();

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vedic_mac_acc.md
Name: vedic_mac_acc

Overview:
- Streaming multiply-accumulate stage downstream of vedic_8bits; computes dot products of 8-bit unsigned operand streams.
- Accepts (A,B) pairs over a valid/ready handshake and multiplies each pair with an internal vedic_8bits instance.
- Accumulates LEN products into an ACC_W-bit sum and presents the sum on a valid/ready output port.

Parameters:
ACC_W  24  accumulator/result width, >=16; default covers 255 products of 255*255 with no overflow
CNT_W  8   width of LEN and the element counter

Ports:
CLK        in   1      clock, rising edge
RST_n      in   1      asynchronous active-low reset
CLR        in   1      synchronous clear: flush pipeline, zero accumulator, return to IDLE
LEN        in   CNT_W  products per dot product; sampled on first accept of a vector; 0 treated as 1
IN_VALID   in   1      operand pair valid
IN_READY   out  1      block accepts a pair this cycle
A          in   8      unsigned operand
B          in   8      unsigned operand
OUT_VALID  out  1      result valid
OUT_READY  in   1      consumer takes result
ACC        out  ACC_W  dot-product result, mod 2^ACC_W
OVF        out  1      carry out of ACC_W occurred during this vector

Behaviour:
- Reset (RST_n low, asynchronous): state IDLE, counter 0, pipeline valids 0, accumulator 0.
  - Output values during reset: IN_READY=0, OUT_VALID=0, ACC=0, OVF=0.
  - IN_READY is gated by a ready-enable flop cleared by reset, so it stays 0 for the first cycle after release.
- Accept occurs on a rising edge with IN_VALID & IN_READY.
- Pipeline, each stage with its own valid bit:
  - S1 registers A,B.
  - S2 registers the 16-bit vedic_8bits product of S1.
  - S3 adds the zero-extended product into the accumulator.
- Throughput is one pair per cycle in IDLE/RUN.
- Latency: OUT_VALID rises 3 edges after the edge that accepts the last pair of a vector.
- FSM:
  - IDLE: IN_READY=1.
    - On accept: len_r <= max(LEN,1); cnt <= 1.
    - Go to DRAIN if len_r==1, else RUN.
  - RUN: IN_READY=1.
    - Each accept increments cnt.
    - The accept that makes cnt==len_r goes to DRAIN.
    - IN_VALID low just inserts bubbles; no timeout.
  - DRAIN: IN_READY=0.
    - Wait until S1 and S2 valids are both 0 and the final S3 add has completed.
    - Then go to DONE.
  - DONE: OUT_VALID=1; ACC and OVF held stable; IN_READY=0, so IN_VALID is ignored.
    - On OUT_READY: go to IDLE and zero the accumulator and OVF on the same edge.
    - IN_READY returns to 1 the next cycle. Vectors never overlap.
- LEN is ignored after the first accept of a vector.
- Arithmetic: acc_next = acc + {0,P}, computed at ACC_W+1 bits.
  - Bit ACC_W of the sum sets sticky OVF; ACC keeps the low ACC_W bits (wrap).
- ACC is the registered accumulator; it changes only on S3 adds, CLR, reset or DONE handoff.
- CLR priority: RST_n > CLR > all else.
  - CLR discards in-flight pairs and does not perform an accept that cycle (IN_READY=0 while CLR high).
  - Next cycle: IDLE, ACC=0, OVF=0, OUT_VALID=0.
- Reset or CLR mid-vector: partial sum discarded; the next vector starts clean.
- OUT_READY while OUT_VALID=0: ignored.

Test Plan:
1. LEN=4; pairs (3,5),(255,255),(16,16),(0,200) back-to-back, OUT_READY=1.
   -> ACC=65296 (15+65025+256+0), OVF=0, OUT_VALID exactly 3 cycles after the 4th accept, high for 1 cycle.
2. LEN=1 with (200,100) -> ACC=20000. Then LEN=0 with (7,9) -> treated as 1, ACC=63.
3. LEN=2, (10,10),(20,20); hold OUT_READY=0 for 10 cycles while driving IN_VALID=1.
   -> ACC=500 stable, OUT_VALID=1, IN_READY=0, no pair accepted.
   After OUT_READY=1: IN_READY returns 1 the next cycle; a following vector LEN=1 (1,1) gives ACC=1, not 501.
4. LEN=3, pairs (12,12),(1,255),(128,2) with 2-cycle IN_VALID gaps between pairs.
   -> ACC=655 (144+255+256); no extra accepts; cnt stops at 3.
5. ACC_W=16 override, LEN=2, (255,255) twice -> ACC=64514 (130050 mod 65536), OVF=1.
   Next vector LEN=1 (1,1) -> ACC=1, OVF=0.
6. LEN=4: accept 2 pairs, pulse CLR, then run LEN=2 (2,3),(4,5) -> ACC=26.
   Repeat with an RST_n low pulse instead of CLR -> outputs 0 during reset, then ACC=26.
